// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a FIFO write port.
// Bounded bursts per grant; never writes while the FIFO reports full.
//
// state  | meaning
// IDLE   | no grant held; picks a requester for the next cycle
// SERVE0 | producer 0 owns the FIFO write port
// SERVE1 | producer 1 owns the FIFO write port
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic [DATA_WIDTH-1:0] i_data0,
    output logic                  o_ack0,
    input  logic                  i_req1,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic                  o_ack1,
    input  logic                  i_full,
    output logic                  o_w_en,
    output logic [DATA_WIDTH-1:0] o_w_data,
    output logic                  o_grant0,
    output logic                  o_grant1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    localparam logic [7:0] LP_BURST_LAST = 8'(MAX_BURST - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_burst_cnt;
    logic [7:0]            w_burst_cnt_nxt;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  w_serve;
    logic                  w_sel;
    logic                  w_req_sel;
    logic                  w_req_oth;
    logic                  w_xfer;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_data_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= 8'd0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_last      <= w_last_nxt;
        end
    end

    // Both SERVE states share one datapath, steered by w_sel.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_last_nxt      = r_last;
        w_serve         = (r_state == SERVE0) || (r_state == SERVE1);
        w_sel           = (r_state == SERVE1);
        w_req_sel       = w_sel ? i_req1 : i_req0;
        w_req_oth       = w_sel ? i_req0 : i_req1;
        w_data_sel      = w_sel ? i_data1 : i_data0;
        w_xfer          = w_serve & w_req_sel & ~i_full;
        w_release       = w_serve & (~w_req_sel |
                          (w_xfer & (r_burst_cnt == LP_BURST_LAST)));

        case (r_state)
            IDLE: begin
                if (i_req0 && i_req1) begin
                    w_state_nxt = r_last ? SERVE0 : SERVE1;
                end else if (i_req0) begin
                    w_state_nxt = SERVE0;
                end else if (i_req1) begin
                    w_state_nxt = SERVE1;
                end
            end
            SERVE0, SERVE1: begin
                if (w_xfer) begin
                    w_burst_cnt_nxt = r_burst_cnt + 8'd1;
                end
                if (w_release) begin
                    w_last_nxt      = w_sel;
                    w_burst_cnt_nxt = 8'd0;
                    if (w_req_oth) begin
                        w_state_nxt = w_sel ? SERVE0 : SERVE1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_ack0   = w_xfer & ~w_sel;
    assign o_ack1   = w_xfer & w_sel;
    assign o_w_en   = w_xfer;
    assign o_w_data = w_serve ? w_data_sel : '0;
    assign o_grant0 = (r_state == SERVE0);
    assign o_grant1 = (r_state == SERVE1);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level ownership model.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0;
    logic          req1;
    logic          full;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          ack0;
    logic          ack1;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          grant0;
    logic          grant1;

    int n_vec = 0;
    int n_err = 0;

    // Model: who owns the port (-1 none), words written this grant, last releaser.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 1;

    logic [DW+4:0] obs_v;
    logic [DW+4:0] exp_v;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req0   (req0),
        .i_data0  (data0),
        .o_ack0   (ack0),
        .i_req1   (req1),
        .i_data1  (data1),
        .o_ack1   (ack1),
        .i_full   (full),
        .o_w_en   (w_en),
        .o_w_data (w_data),
        .o_grant0 (grant0),
        .o_grant1 (grant1)
    );

    always #5 clk = ~clk;

    assign obs_v = {ack0, ack1, w_en, grant0, grant1, w_data};

    function automatic logic [DW+4:0] model_exp();
        logic a0, a1, g0, g1;
        logic [DW-1:0] d;
        a0 = 1'b0; a1 = 1'b0; g0 = 1'b0; g1 = 1'b0; d = '0;
        if (m_owner == 0) begin
            g0 = 1'b1; a0 = req0 && !full; d = data0;
        end else if (m_owner == 1) begin
            g1 = 1'b1; a1 = req1 && !full; d = data1;
        end
        return {a0, a1, a0 | a1, g0, g1, d};
    endfunction

    task automatic model_step();
        int  k;
        bit  rk, ro, xfer;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = 1;
        end else if (m_owner < 0) begin
            if (req0 && req1) m_owner = 1 - m_last;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
        end else begin
            k    = m_owner;
            rk   = (k == 1) ? req1 : req0;
            ro   = (k == 1) ? req0 : req1;
            xfer = rk && !full;
            if (xfer) m_cnt++;
            if (!rk || (xfer && m_cnt == MB)) begin
                m_last  = k;
                m_cnt   = 0;
                m_owner = ro ? 1 - k : -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        exp_v = model_exp();
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; full = 1'b0;
        data0 = 8'h55; data1 = 8'hAA;
        tick();
        for (int c = 0; c < 2; c++) begin
            sample();
            n_vec++;
            if (obs_v !== '0) begin
                n_err++;
                $display("FAIL reset_outputs c%0d: got %h want 0", c, obs_v);
            end
            if (c == 0) tick();
        end
        tick();
        rst = 1'b0;
        sample();
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL reset_release_idle: got %h want %h", obs_v, exp_v);
        end
        tick();
        sample();
        n_vec++;
        if ({grant0, ack0, w_data} !== {1'b1, 1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL reset_first_grant: got g0=%b a0=%b d=%h want 1 1 55",
                     grant0, ack0, w_data);
        end
        tick();
    endtask

    task automatic test_single();
        int         idx;
        int         nw;
        logic [9:0] trace;
        logic [7:0] wr [6];
        bit         a0;
        do_reset();
        req0 = 1'b1; data0 = 8'h10; idx = 0; nw = 0; trace = '0;
        for (int c = 0; c < 10; c++) begin
            sample();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL single_cycle c%0d: got %h want %h", c, obs_v, exp_v);
            end
            trace = {trace[8:0], w_en};
            if (w_en && nw < 6) begin wr[nw] = w_data; nw++; end
            a0 = exp_v[DW+4];
            tick();
            if (a0) begin
                idx++;
                if (idx == 6) req0 = 1'b0;
                else data0 = 8'(8'h10 + idx);
            end
        end
        n_vec++;
        if (trace !== 10'b0111101100) begin
            n_err++;
            $display("FAIL single_wen_trace: got %b want 0111101100", trace);
        end
        n_vec++;
        if (nw != 6) begin
            n_err++;
            $display("FAIL single_word_count: got %0d want 6", nw);
        end
        for (int i = 0; i < nw; i++) begin
            n_vec++;
            if (wr[i] !== 8'(8'h10 + i)) begin
                n_err++;
                $display("FAIL single_data w%0d: got %h want %h", i, wr[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_both();
        logic [12:0] t_en;
        logic [12:0] t_who;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hA0; data1 = 8'hB0;
        t_en = '0; t_who = '0;
        for (int c = 0; c < 13; c++) begin
            sample();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL both_cycle c%0d: got %h want %h", c, obs_v, exp_v);
            end
            t_en  = {t_en[11:0], w_en};
            t_who = {t_who[11:0], ack1};
            tick();
            data0 = data0 + 8'd1;
            data1 = data1 + 8'd1;
        end
        n_vec++;
        if ({t_en, t_who} !== {13'b0111111111111, 13'b0000011110000}) begin
            n_err++;
            $display("FAIL both_pattern: got en=%b who=%b want en=0111111111111 who=0000011110000",
                     t_en, t_who);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [2:0] tab [9];
        tab = '{3'b000, 3'b110, 3'b110, 3'b010, 3'b010, 3'b010, 3'b110, 3'b110, 3'b101};
        do_reset();
        req0 = 1'b1; data0 = 8'h20;
        for (int c = 0; c < 9; c++) begin
            sample();
            n_vec++;
            if (obs_v !== exp_v || {w_en, grant0, grant1} !== tab[c]) begin
                n_err++;
                $display("FAIL full_stall c%0d: got %h (en/g0/g1=%b) want %h (%b)",
                         c, obs_v, {w_en, grant0, grant1}, exp_v, tab[c]);
            end
            tick();
            if (c == 1 || c == 2 || c == 6 || c == 7) data0 = data0 + 8'd1;
            if (c == 2) begin full = 1'b1; req1 = 1'b1; data1 = 8'h30; end
            if (c == 5) full = 1'b0;
            if (c == 7) req0 = 1'b0;
        end
        req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_early_release();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h41; data1 = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            sample();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL early_cycle c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c == 3) begin
                n_vec++;
                if ({grant1, ack1, w_data} !== {1'b1, 1'b1, 8'h5A}) begin
                    n_err++;
                    $display("FAIL early_handover: got g1=%b a1=%b d=%h want 1 1 5a",
                             grant1, ack1, w_data);
                end
            end
            tick();
            if (c == 1) req0 = 1'b0;
            if (c == 3) req1 = 1'b0;
        end
        do_reset();
        req0 = 1'b1; data0 = 8'h61;
        for (int c = 0; c < 5; c++) begin
            sample();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL early_last_cycle c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c == 4) begin
                n_vec++;
                if ({grant0, grant1} !== 2'b01) begin
                    n_err++;
                    $display("FAIL early_last_pick: got g0g1=%b want 01", {grant0, grant1});
                end
            end
            tick();
            if (c == 1) req0 = 1'b0;
            if (c == 2) begin req0 = 1'b1; req1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req1 = 1'b1; data1 = 8'h77; data0 = 8'h66;
        for (int c = 0; c < 6; c++) begin
            sample();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL midrst_cycle c%0d: got %h want %h", c, obs_v, exp_v);
            end
            if (c == 4) begin
                n_vec++;
                if (obs_v !== '0) begin
                    n_err++;
                    $display("FAIL midrst_idle: got %h want 0", obs_v);
                end
            end
            if (c == 5) begin
                n_vec++;
                if ({grant0, ack0, grant1} !== 3'b110) begin
                    n_err++;
                    $display("FAIL midrst_winner: got g0/a0/g1=%b want 110",
                             {grant0, ack0, grant1});
                end
            end
            tick();
            if (c == 2) begin rst = 1'b1; req0 = 1'b1; end
            if (c == 3) rst = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_random();
        bit a0, a1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            full = ($urandom_range(0, 99) < 25);
            rst  = ($urandom_range(0, 199) == 0);
            sample();
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL random_cycle c%0d: got %h want %h", c, obs_v, exp_v);
            end
            a0 = exp_v[DW+4];
            a1 = exp_v[DW+3];
            tick();
            if (!req0 || a0) begin
                req0  = ($urandom_range(0, 3) != 0);
                data0 = 8'($urandom);
            end
            if (!req1 || a1) begin
                req1  = ($urandom_range(0, 3) != 0);
                data1 = 8'($urandom);
            end
        end
        rst = 1'b0; full = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0;
        data0 = '0; data1 = '0;
        test_reset();
        test_single();
        test_both();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
